sdram_ctrl: RTL and testbench

SDRAM_CTRL -- requirements
Module: sdram_ctrl

---
 rtl/sdram_ctrl_pkg.sv | 58 +++++
 rtl/sdram_ctrl_if.sv | 34 +++
 rtl/sdram_ref_timer.sv | 47 ++++
 rtl/sdram_ctrl.sv | 138 +++++++++++++
 tb/tb_sdram_ctrl.sv | 246 ++++++++++++++++++++++++
 5 files changed

// File: rtl/sdram_ctrl_pkg.sv
// rtl/sdram_ctrl_pkg.sv - shared SDRAM controller state codes, timing defaults and burst limits
//
// Purpose: init/work state encodings, default timing parameters, burst-length
// limits and small helpers shared by the command stage and refresh timer.
package sdram_ctrl_pkg;

  typedef enum logic [3:0] {
    I_NOP  = 4'd0,
    I_PRE  = 4'd1,
    I_TRP  = 4'd2,
    I_AR1  = 4'd3,
    I_TRF1 = 4'd4,
    I_AR2  = 4'd5,
    I_TRF2 = 4'd6,
    I_MRS  = 4'd7,
    I_TMRD = 4'd8,
    I_DONE = 4'd9
  } init_state_t;

  typedef enum logic [3:0] {
    W_IDLE   = 4'd0,
    W_ACTIVE = 4'd1,
    W_TRCD   = 4'd2,
    W_READ   = 4'd3,
    W_CL     = 4'd4,
    W_RD     = 4'd5,
    W_WRITE  = 4'd6,
    W_WD     = 4'd7,
    W_TDAL   = 4'd8,
    W_AR     = 4'd9,
    W_TRFC   = 4'd10
  } work_state_t;

  localparam int DEF_T_PWR_UP     = 20000;
  localparam int DEF_T_RP         = 2;
  localparam int DEF_T_RFC        = 7;
  localparam int DEF_T_MRD        = 2;
  localparam int DEF_T_RCD        = 2;
  localparam int DEF_CL           = 3;
  localparam int DEF_T_DAL        = 4;
  localparam int DEF_REF_INTERVAL = 1560;

  localparam logic [8:0] BURST_MIN = 9'd1;
  localparam logic [8:0] BURST_MAX = 9'd256;

  // A zero-length burst still moves one beat; anything above 256 is capped.
  function automatic logic [8:0] clamp_burst(input logic [8:0] n);
    if (n < BURST_MIN) return BURST_MIN;
    if (n > BURST_MAX) return BURST_MAX;
    return n;
  endfunction

  // An N-cycle wait state is finished on the cycle its counter reads N-1.
  function automatic logic wait_over(input logic [8:0] cnt, input int n);
    return cnt == 9'(n - 1);
  endfunction

endpackage

// File: rtl/sdram_ctrl_if.sv
// rtl/sdram_ctrl_if.sv - host-side request/grant and status bundle of the SDRAM controller
//
// Ports (slave = controller view):
//   in : rd_req, wr_req, sdrd_byte[8:0], sdwr_byte[8:0]
//   out: init_state[3:0], work_state[3:0], cnt_clk[8:0], sys_r_wn, init_done,
//        busy, rd_ack, wr_ack, rd_data_valid, wr_data_en
interface sdram_ctrl_if;
  logic       rd_req;
  logic       wr_req;
  logic [8:0] sdrd_byte;
  logic [8:0] sdwr_byte;
  logic [3:0] init_state;
  logic [3:0] work_state;
  logic [8:0] cnt_clk;
  logic       sys_r_wn;
  logic       init_done;
  logic       busy;
  logic       rd_ack;
  logic       wr_ack;
  logic       rd_data_valid;
  logic       wr_data_en;

  modport slave (
    input  rd_req, wr_req, sdrd_byte, sdwr_byte,
    output init_state, work_state, cnt_clk, sys_r_wn, init_done, busy,
           rd_ack, wr_ack, rd_data_valid, wr_data_en
  );

  modport master (
    output rd_req, wr_req, sdrd_byte, sdwr_byte,
    input  init_state, work_state, cnt_clk, sys_r_wn, init_done, busy,
           rd_ack, wr_ack, rd_data_valid, wr_data_en
  );
endinterface

// File: rtl/sdram_ref_timer.sv
// rtl/sdram_ref_timer.sv - refresh interval counter and pending-refresh flag
//
// Ports: clk, rst_n (sync, active-low); en_i counts while high; clr_i clears the
// pending flag; ref_pending_o requests an auto-refresh.
module sdram_ref_timer
  import sdram_ctrl_pkg::*;
#(
  parameter int REF_INTERVAL = DEF_REF_INTERVAL
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en_i,
  input  logic clr_i,
  output logic ref_pending_o
);

  localparam int CW = ($clog2(REF_INTERVAL) > 0) ? $clog2(REF_INTERVAL) : 1;
  localparam logic [CW-1:0] LAST = CW'(REF_INTERVAL - 1);

  logic [CW-1:0] cnt_q, cnt_d;
  logic          pend_q, pend_d;
  logic          expire;

  always_comb begin
    expire = en_i && (cnt_q == LAST);
    cnt_d  = cnt_q;
    if (en_i) cnt_d = expire ? '0 : cnt_q + 1'b1;
    // A fresh expiry on the same cycle the refresh is granted must not be lost;
    // a repeated expiry while still pending simply leaves the flag set.
    pend_d = pend_q;
    if (clr_i) pend_d = 1'b0;
    if (expire) pend_d = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q  <= '0;
      pend_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      pend_q <= pend_d;
    end
  end

  assign ref_pending_o = pend_q;

endmodule

// File: rtl/sdram_ctrl.sv
// rtl/sdram_ctrl.sv - SDRAM controller command stage: init sequence, arbitration and access timing
//
// Ports: clk, rst_n (sync, active-low); host (sdram_ctrl_if.slave) carries the
// read/write requests, burst lengths, grants, data-beat strobes and state codes.
module sdram_ctrl
  import sdram_ctrl_pkg::*;
#(
  parameter int T_PWR_UP     = DEF_T_PWR_UP,
  parameter int T_RP         = DEF_T_RP,
  parameter int T_RFC        = DEF_T_RFC,
  parameter int T_MRD        = DEF_T_MRD,
  parameter int T_RCD        = DEF_T_RCD,
  parameter int CL           = DEF_CL,
  parameter int T_DAL        = DEF_T_DAL,
  parameter int REF_INTERVAL = DEF_REF_INTERVAL
) (
  input  logic         clk,
  input  logic         rst_n,
  sdram_ctrl_if.slave  host
);

  init_state_t init_q, init_d;
  work_state_t work_q, work_d;
  logic [8:0]  cnt_q, cnt_d;
  logic [14:0] pwr_q, pwr_d;
  logic        srwn_q, srwn_d;
  logic [8:0]  burst_q, burst_d;
  logic        init_done;
  logic        ref_pending;
  logic        ref_grant;

  assign init_done = (init_q == I_DONE);

  sdram_ref_timer #(.REF_INTERVAL(REF_INTERVAL)) u_ref (
    .clk           (clk),
    .rst_n         (rst_n),
    .en_i          (init_done),
    .clr_i         (ref_grant),
    .ref_pending_o (ref_pending)
  );

  always_comb begin
    init_d = init_q;
    pwr_d  = pwr_q;
    case (init_q)
      I_NOP: begin
        pwr_d = pwr_q + 15'd1;
        if (pwr_q == 15'(T_PWR_UP - 1)) init_d = I_PRE;
      end
      I_PRE:  init_d = I_TRP;
      I_TRP:  if (wait_over(cnt_q, T_RP)) init_d = I_AR1;
      I_AR1:  init_d = I_TRF1;
      I_TRF1: if (wait_over(cnt_q, T_RFC)) init_d = I_AR2;
      I_AR2:  init_d = I_TRF2;
      I_TRF2: if (wait_over(cnt_q, T_RFC)) init_d = I_MRS;
      I_MRS:  init_d = I_TMRD;
      I_TMRD: if (wait_over(cnt_q, T_MRD)) init_d = I_DONE;
      I_DONE: init_d = I_DONE;
      default: init_d = I_NOP;
    endcase
  end

  always_comb begin
    work_d    = work_q;
    srwn_d    = srwn_q;
    burst_d   = burst_q;
    ref_grant = 1'b0;
    case (work_q)
      W_IDLE: begin
        if (init_done) begin
          if (ref_pending) begin
            work_d    = W_AR;
            ref_grant = 1'b1;
          end else if (host.rd_req) begin
            work_d = W_ACTIVE;
            srwn_d = 1'b1;
          end else if (host.wr_req) begin
            work_d = W_ACTIVE;
            srwn_d = 1'b0;
          end
        end
      end
      W_ACTIVE: begin
        // Length is frozen here so the host may change it once granted.
        burst_d = clamp_burst(srwn_q ? host.sdrd_byte : host.sdwr_byte);
        work_d  = W_TRCD;
      end
      W_TRCD:  if (wait_over(cnt_q, T_RCD)) work_d = srwn_q ? W_READ : W_WRITE;
      W_READ:  work_d = W_CL;
      W_CL:    if (wait_over(cnt_q, CL)) work_d = W_RD;
      W_RD:    if (cnt_q == burst_q - 9'd1) work_d = W_IDLE;
      // W_WRITE carries the first beat, so W_WD only covers the remaining ones.
      W_WRITE: work_d = (burst_q == 9'd1) ? W_TDAL : W_WD;
      W_WD:    if (cnt_q == burst_q - 9'd2) work_d = W_TDAL;
      W_TDAL:  if (wait_over(cnt_q, T_DAL)) work_d = W_IDLE;
      W_AR:    work_d = W_TRFC;
      W_TRFC:  if (wait_over(cnt_q, T_RFC)) work_d = W_IDLE;
      default: work_d = W_IDLE;
    endcase
  end

  // Only one of the two FSMs moves at a time, so a single counter serves both.
  always_comb begin
    if ((init_d != init_q) || (work_d != work_q)) cnt_d = 9'd0;
    else if (cnt_q == 9'd511)                     cnt_d = cnt_q;
    else                                          cnt_d = cnt_q + 9'd1;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      init_q  <= I_NOP;
      work_q  <= W_IDLE;
      cnt_q   <= 9'd0;
      pwr_q   <= 15'd0;
      srwn_q  <= 1'b0;
      burst_q <= 9'd1;
    end else begin
      init_q  <= init_d;
      work_q  <= work_d;
      cnt_q   <= cnt_d;
      pwr_q   <= pwr_d;
      srwn_q  <= srwn_d;
      burst_q <= burst_d;
    end
  end

  assign host.init_state    = init_q;
  assign host.work_state    = work_q;
  assign host.cnt_clk       = cnt_q;
  assign host.sys_r_wn      = srwn_q;
  assign host.init_done     = init_done;
  assign host.busy          = !init_done || (work_q != W_IDLE);
  assign host.rd_ack        = (work_q == W_ACTIVE) && srwn_q;
  assign host.wr_ack        = (work_q == W_ACTIVE) && !srwn_q;
  assign host.rd_data_valid = (work_q == W_RD);
  assign host.wr_data_en    = (work_q == W_WRITE) || (work_q == W_WD);

endmodule

// File: tb/tb_sdram_ctrl.sv
// tb/tb_sdram_ctrl.sv - directed self-checking bench for sdram_ctrl
module tb_sdram_ctrl;

  logic clk;
  logic rst_n;
  sdram_ctrl_if bus();

  sdram_ctrl #(.T_PWR_UP(10), .REF_INTERVAL(200)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .host  (bus)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  int st_cnt [16];
  int n_rack, n_wack, n_valid, n_wen, n_total, ack_srwn;

  task automatic do_reset();
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic wait_init(output int n);
    n = -1;
    for (int c = 1; c <= 100; c++) begin
      @(negedge clk);
      if (bus.init_done === 1'b1) begin
        n = c;
        break;
      end
    end
  endtask

  // Drives one request from an idle cycle (cycle 0) and tallies what follows
  // until the controller is back in W_IDLE; n_total is that idle cycle index.
  task automatic access(input bit rd, input logic [8:0] len);
    for (int i = 0; i < 16; i++) st_cnt[i] = 0;
    n_rack = 0; n_wack = 0; n_valid = 0; n_wen = 0; n_total = -1; ack_srwn = -1;
    if (rd) begin bus.rd_req = 1'b1; bus.sdrd_byte = len; end
    else    begin bus.wr_req = 1'b1; bus.sdwr_byte = len; end
    for (int c = 1; c <= 600; c++) begin
      @(negedge clk);
      if (bus.rd_ack === 1'b1 || bus.wr_ack === 1'b1) begin
        ack_srwn = int'(bus.sys_r_wn);
        bus.rd_req = 1'b0;
        bus.wr_req = 1'b0;
      end
      if (bus.work_state == 4'd2) begin
        bus.sdrd_byte = 9'd9;
        bus.sdwr_byte = 9'd9;
      end
      if (bus.rd_ack === 1'b1) n_rack++;
      if (bus.wr_ack === 1'b1) n_wack++;
      if (bus.rd_data_valid === 1'b1) n_valid++;
      if (bus.wr_data_en === 1'b1) n_wen++;
      if (bus.work_state == 4'd0) begin
        n_total = c;
        break;
      end
      st_cnt[bus.work_state]++;
    end
  endtask

  task automatic test_reset();
    logic [23:0] obs, exp_v;
    rst_n = 1'b0;
    @(negedge clk);
    @(negedge clk);
    exp_v = {4'd0, 4'd0, 9'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    obs = {bus.init_state, bus.work_state, bus.cnt_clk, bus.sys_r_wn, bus.init_done, bus.busy,
           bus.rd_ack, bus.wr_ack, bus.rd_data_valid, bus.wr_data_en};
    checks++; if (obs !== exp_v) begin errors++; $display("FAIL reset_outputs: got %h expected %h", obs, exp_v); end
    checks++; if (dut.ref_pending !== 1'b0) begin errors++; $display("FAIL reset_ref_pending: got %b expected 0", dut.ref_pending); end
  endtask

  task automatic test_init();
    int dur [9] = '{10, 1, 2, 1, 7, 1, 7, 1, 2};
    int exp_st [41];
    int exp_cnt [41];
    int k = 0;
    for (int s = 0; s < 9; s++)
      for (int j = 0; j < dur[s]; j++) begin exp_st[k] = s; exp_cnt[k] = j; k++; end
    for (int m = k; m <= 40; m++) begin exp_st[m] = 9; exp_cnt[m] = m - 32; end
    do_reset();
    for (int c = 0; c <= 40; c++) begin
      if (c > 0) @(negedge clk);
      checks++; if (bus.init_state !== 4'(exp_st[c])) begin errors++; $display("FAIL init_state@%0d: got %0d expected %0d", c, bus.init_state, exp_st[c]); end
      checks++; if (bus.cnt_clk !== 9'(exp_cnt[c])) begin errors++; $display("FAIL init_cnt_clk@%0d: got %0d expected %0d", c, bus.cnt_clk, exp_cnt[c]); end
      checks++; if (bus.init_done !== (c >= 32)) begin errors++; $display("FAIL init_done@%0d: got %b expected %b", c, bus.init_done, c >= 32); end
      checks++; if (bus.busy !== (c < 32)) begin errors++; $display("FAIL init_busy@%0d: got %b expected %b", c, bus.busy, c < 32); end
      checks++; if (bus.work_state !== 4'd0) begin errors++; $display("FAIL init_work_state@%0d: got %0d expected 0", c, bus.work_state); end
    end
  endtask

  task automatic test_read();
    int n;
    do_reset();
    wait_init(n);
    checks++; if (n !== 32) begin errors++; $display("FAIL read_init_latency: got %0d expected 32", n); end
    access(1'b1, 9'd4);
    checks++; if (n_rack !== 1) begin errors++; $display("FAIL read_rd_ack: got %0d expected 1", n_rack); end
    checks++; if (n_wack !== 0) begin errors++; $display("FAIL read_wr_ack: got %0d expected 0", n_wack); end
    checks++; if (ack_srwn !== 1) begin errors++; $display("FAIL read_sys_r_wn: got %0d expected 1", ack_srwn); end
    checks++; if (st_cnt[2] !== 2) begin errors++; $display("FAIL read_trcd: got %0d expected 2", st_cnt[2]); end
    checks++; if (st_cnt[3] !== 1) begin errors++; $display("FAIL read_read: got %0d expected 1", st_cnt[3]); end
    checks++; if (st_cnt[4] !== 3) begin errors++; $display("FAIL read_cl: got %0d expected 3", st_cnt[4]); end
    checks++; if (st_cnt[5] !== 4) begin errors++; $display("FAIL read_rd_state: got %0d expected 4", st_cnt[5]); end
    checks++; if (n_valid !== 4) begin errors++; $display("FAIL read_valid_beats: got %0d expected 4", n_valid); end
    checks++; if (n_wen !== 0) begin errors++; $display("FAIL read_wr_en: got %0d expected 0", n_wen); end
    checks++; if (n_total !== 12) begin errors++; $display("FAIL read_idle_at: got %0d expected 12", n_total); end
    access(1'b1, 9'd0);
    checks++; if (n_valid !== 1) begin errors++; $display("FAIL read0_valid_beats: got %0d expected 1", n_valid); end
    checks++; if (n_total !== 9) begin errors++; $display("FAIL read0_idle_at: got %0d expected 9", n_total); end
  endtask

  task automatic test_write();
    int n;
    do_reset();
    wait_init(n);
    access(1'b0, 9'd1);
    checks++; if (n_wack !== 1) begin errors++; $display("FAIL wr1_wr_ack: got %0d expected 1", n_wack); end
    checks++; if (ack_srwn !== 0) begin errors++; $display("FAIL wr1_sys_r_wn: got %0d expected 0", ack_srwn); end
    checks++; if (st_cnt[6] !== 1) begin errors++; $display("FAIL wr1_write: got %0d expected 1", st_cnt[6]); end
    checks++; if (st_cnt[7] !== 0) begin errors++; $display("FAIL wr1_wd: got %0d expected 0", st_cnt[7]); end
    checks++; if (st_cnt[8] !== 4) begin errors++; $display("FAIL wr1_tdal: got %0d expected 4", st_cnt[8]); end
    checks++; if (n_wen !== 1) begin errors++; $display("FAIL wr1_wr_en: got %0d expected 1", n_wen); end
    checks++; if (n_total !== 9) begin errors++; $display("FAIL wr1_idle_at: got %0d expected 9", n_total); end
    access(1'b0, 9'd3);
    checks++; if (st_cnt[7] !== 2) begin errors++; $display("FAIL wr3_wd: got %0d expected 2", st_cnt[7]); end
    checks++; if (n_wen !== 3) begin errors++; $display("FAIL wr3_wr_en: got %0d expected 3", n_wen); end
    checks++; if (n_total !== 11) begin errors++; $display("FAIL wr3_idle_at: got %0d expected 11", n_total); end
    access(1'b0, 9'd300);
    checks++; if (n_wen !== 256) begin errors++; $display("FAIL wr300_wr_en: got %0d expected 256", n_wen); end
    checks++; if (st_cnt[7] !== 255) begin errors++; $display("FAIL wr300_wd: got %0d expected 255", st_cnt[7]); end
    checks++; if (n_total !== 264) begin errors++; $display("FAIL wr300_idle_at: got %0d expected 264", n_total); end
  endtask

  task automatic test_simultaneous();
    int n, rd_c, wr_c, rd_srwn, wr_srwn, racks;
    do_reset();
    wait_init(n);
    rd_c = -1; wr_c = -1; rd_srwn = -1; wr_srwn = -1; racks = 0;
    bus.rd_req = 1'b1; bus.sdrd_byte = 9'd2;
    bus.wr_req = 1'b1; bus.sdwr_byte = 9'd1;
    for (int c = 1; c <= 60; c++) begin
      @(negedge clk);
      if (bus.rd_ack === 1'b1) begin racks++; rd_c = c; rd_srwn = int'(bus.sys_r_wn); bus.rd_req = 1'b0; end
      if (bus.wr_ack === 1'b1) begin wr_c = c; wr_srwn = int'(bus.sys_r_wn); bus.wr_req = 1'b0; break; end
    end
    checks++; if (rd_c !== 1) begin errors++; $display("FAIL simul_rd_ack_at: got %0d expected 1", rd_c); end
    checks++; if (rd_srwn !== 1) begin errors++; $display("FAIL simul_rd_sys_r_wn: got %0d expected 1", rd_srwn); end
    checks++; if (wr_c !== 11) begin errors++; $display("FAIL simul_wr_ack_at: got %0d expected 11", wr_c); end
    checks++; if (wr_srwn !== 0) begin errors++; $display("FAIL simul_wr_sys_r_wn: got %0d expected 0", wr_srwn); end
    checks++; if (racks !== 1) begin errors++; $display("FAIL simul_rd_grants: got %0d expected 1", racks); end
  endtask

  task automatic test_refresh();
    int n, wen, pend_c, pend_st, ar_c, n_ar, n_trfc, rack_c, done_c;
    logic pend_at_ar;
    do_reset();
    wait_init(n);
    wen = 0; pend_c = -1; pend_st = -1; ar_c = -1; n_ar = 0; n_trfc = 0; rack_c = -1; done_c = -1;
    pend_at_ar = 1'bx;
    bus.wr_req = 1'b1; bus.sdwr_byte = 9'd256;
    for (int c = 1; c <= 400; c++) begin
      @(negedge clk);
      if (bus.wr_ack === 1'b1) begin bus.wr_req = 1'b0; bus.rd_req = 1'b1; bus.sdrd_byte = 9'd1; end
      if (bus.rd_ack === 1'b1 && rack_c < 0) begin rack_c = c; bus.rd_req = 1'b0; end
      if (bus.wr_data_en === 1'b1) wen++;
      if (dut.ref_pending === 1'b1 && pend_c < 0) begin pend_c = c; pend_st = int'(bus.work_state); end
      if (bus.work_state == 4'd9) begin
        if (ar_c < 0) begin ar_c = c; pend_at_ar = dut.ref_pending; end
        n_ar++;
      end
      if (bus.work_state == 4'd10) n_trfc++;
      if (rack_c > 0 && bus.work_state == 4'd0) begin done_c = c; break; end
    end
    checks++; if (wen !== 256) begin errors++; $display("FAIL ref_wr_beats: got %0d expected 256", wen); end
    checks++; if (pend_c !== 200) begin errors++; $display("FAIL ref_pending_at: got %0d expected 200", pend_c); end
    checks++; if (pend_st !== 7) begin errors++; $display("FAIL ref_pending_state: got %0d expected 7", pend_st); end
    checks++; if (ar_c !== 265) begin errors++; $display("FAIL ref_ar_at: got %0d expected 265", ar_c); end
    checks++; if (pend_at_ar !== 1'b0) begin errors++; $display("FAIL ref_pending_cleared: got %b expected 0", pend_at_ar); end
    checks++; if (n_ar !== 1) begin errors++; $display("FAIL ref_ar_cycles: got %0d expected 1", n_ar); end
    checks++; if (n_trfc !== 7) begin errors++; $display("FAIL ref_trfc_cycles: got %0d expected 7", n_trfc); end
    checks++; if (rack_c !== 274) begin errors++; $display("FAIL ref_rd_ack_at: got %0d expected 274", rack_c); end
    checks++; if (done_c !== 282) begin errors++; $display("FAIL ref_rd_done_at: got %0d expected 282", done_c); end
  endtask

  task automatic test_reset_mid_read();
    int n;
    bit hit;
    logic [23:0] obs, exp_v;
    do_reset();
    wait_init(n);
    hit = 1'b0;
    bus.rd_req = 1'b1; bus.sdrd_byte = 9'd8;
    for (int c = 1; c <= 40; c++) begin
      @(negedge clk);
      if (bus.rd_ack === 1'b1) bus.rd_req = 1'b0;
      if (bus.work_state == 4'd5) begin hit = 1'b1; break; end
    end
    checks++; if (hit !== 1'b1) begin errors++; $display("FAIL midrd_reach_rd: got %b expected 1", hit); end
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    exp_v = {4'd0, 4'd0, 9'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    obs = {bus.init_state, bus.work_state, bus.cnt_clk, bus.sys_r_wn, bus.init_done, bus.busy,
           bus.rd_ack, bus.wr_ack, bus.rd_data_valid, bus.wr_data_en};
    checks++; if (obs !== exp_v) begin errors++; $display("FAIL midrd_reset_outputs: got %h expected %h", obs, exp_v); end
    for (int k = 1; k <= 10; k++) begin
      @(negedge clk);
      if (k == 9) begin
        checks++; if (bus.init_state !== 4'd0) begin errors++; $display("FAIL midrd_still_nop: got %0d expected 0", bus.init_state); end
      end
      if (k == 10) begin
        checks++; if (bus.init_state !== 4'd1) begin errors++; $display("FAIL midrd_pre: got %0d expected 1", bus.init_state); end
      end
    end
    wait_init(n);
    checks++; if (n !== 22) begin errors++; $display("FAIL midrd_init_again: got %0d expected 22", n); end
  endtask

  initial begin
    clk = 1'b0;
    rst_n = 1'b0;
    bus.rd_req = 1'b0;
    bus.wr_req = 1'b0;
    bus.sdrd_byte = 9'd1;
    bus.sdwr_byte = 9'd1;
    test_reset();
    test_init();
    test_read();
    test_write();
    test_simultaneous();
    test_refresh();
    test_reset_mid_read();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
